mux16_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one 145-bit 16:1 datapath mux among 16 requesters.
- Picks a winner, drives the 4-bit mux select, and registers the selected 145-bit word into an output stage with a valid/ready handshake.
- Sits between 16 producer slots (e.g. queued pipeline bundles) and a single downstream consumer.
- Instantiates the existing 16:1 145-bit mux internally.

---
 rtl/mux16_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux16_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter over 16 requesters feeding a registered 145-bit output stage.
// Optional ARB_LOCK_EN adds a lock port that pins priority on the current winner.
module mux16_145 #(
  parameter int DW = 145,
  parameter int N  = 16
) (
  input  logic [N*DW-1:0] in_data,
  input  logic [3:0]      sel,
  output logic [DW-1:0]   out
);
  logic [DW-1:0] word [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign word[i] = in_data[i*DW +: DW];
  end

  assign out = word[sel];
endmodule

module mux16_rr_arbiter #(
  parameter int DW = 145,
  parameter int N  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    grant,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [3:0]      out_sel
);
  typedef enum logic {IDLE, FULL} state_t;

  state_t        state, state_nxt;
  logic [3:0]    ptr, ptr_nxt;
  logic [3:0]    winner, mux_sel;
  logic [DW-1:0] mux_out;
  logic          any_req, can_load, cap;

  assign any_req  = |req;
  assign can_load = (state == IDLE) || out_ready;
  assign cap      = can_load && any_req;
  // select tracks out_sel when idle so the mux input is stable between captures
  assign mux_sel  = cap ? winner : out_sel;

  // first requester at or after ptr, wrapping mod 16
  always_comb begin
    logic       found;
    logic [3:0] idx;
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + 4'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign ptr_nxt = lock[winner] ? winner : winner + 4'd1;
`else
  assign ptr_nxt = winner + 4'd1;
`endif

  mux16_145 #(.DW(DW), .N(N)) u_mux (
    .in_data (in_data),
    .sel     (mux_sel),
    .out     (mux_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = FULL;
      FULL:    if (out_ready && !any_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant     = cap ? (N'(1) << winner) : '0;
    out_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (cap) begin
      out_data <= mux_out;
      out_sel  <= winner;
      ptr      <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: reference arbiter model plus a capture scoreboard.
module tb_mux16_rr_arbiter;
  localparam int DW = 145;
  localparam int N  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [3:0]      out_sel;
  logic [N-1:0]    lock;

  mux16_rr_arbiter #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0]      m_ptr;
  logic            m_valid;
  logic [3:0]      m_sel;
  logic [DW-1:0]   m_data;
  logic [DW+3:0]   sb [$];

  task automatic chk(input string tag, input logic [DW+3:0] obs, input logic [DW+3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int seed, input int i);
    logic [DW-1:0] w;
    w          = '0;
    w[15:0]    = 16'(i * 3);
    w[80:65]   = 16'(seed ^ (i << 4));
    w[144:129] = 16'(seed + i);
    return w;
  endfunction

  task automatic set_data(input int seed);
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = mk_word(seed, i);
  endtask

  function automatic logic [3:0] ref_winner(input logic [N-1:0] r, input logic [3:0] p);
    for (int k = 0; k < N; k++) begin
      logic [3:0] idx;
      idx = p + 4'(k);
      if (r[idx]) return idx;
    end
    return p;
  endfunction

  // one clock: check grant mid-cycle, push expected capture, then check registered outputs
  task automatic step(input string tag);
    logic          cap;
    logic [3:0]    w;
    logic [N-1:0]  g_exp;
    logic [DW+3:0] e;
    @(negedge clk);
    w   = ref_winner(req, m_ptr);
    cap = (!m_valid || out_ready) && (req != '0);
    if (rst_n) begin
      g_exp = cap ? (N'(1) << w) : '0;
      chk({tag, ".grant"}, (DW+4)'(grant), (DW+4)'(g_exp));
      if (cap) sb.push_back({w, in_data[w*DW +: DW]});
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_ptr = '0; m_valid = 1'b0; m_sel = '0; m_data = '0;
      sb.delete();
    end else if (cap) begin
      e = sb.pop_front();
      {m_sel, m_data} = e;
      m_valid = 1'b1;
`ifdef ARB_LOCK_EN
      m_ptr = lock[w] ? w : w + 4'd1;
`else
      m_ptr = w + 4'd1;
`endif
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    chk({tag, ".valid"}, (DW+4)'(out_valid), (DW+4)'(m_valid));
    if (m_valid || !rst_n) begin
      chk({tag, ".sel"},  (DW+4)'(out_sel),  (DW+4)'(m_sel));
      chk({tag, ".data"}, (DW+4)'(out_data), (DW+4)'(m_data));
    end
  endtask

  initial begin
    m_ptr = '0; m_valid = 1'b0; m_sel = '0; m_data = '0;
    rst_n = 1'b0; req = '1; out_ready = 1'b1; lock = '0;
    set_data(1);

    // reset with everything requesting
    step("rst0");
    step("rst1");
    rst_n = 1'b1;

    // full load: 0..15 then wrap to 0
    for (int c = 0; c <= N; c++) begin
      set_data(100 + c);
      step("full");
      chk("full.seq", (DW+4)'(out_sel), (DW+4)'(c % N));
    end

    // park ptr at 4 via requester 3, then alternate 5,3
    req = 16'h0008; step("park4");
    req = 16'h0028;
    for (int c = 0; c < 4; c++) begin
      set_data(200 + c);
      step("sparse");
      chk("sparse.seq", (DW+4)'(out_sel), (DW+4)'((c % 2 == 0) ? 5 : 3));
    end

    // backpressure with out_sel=7
    req = 16'h0080; set_data(300); step("load7");
    out_ready = 1'b0; req = '1;
    for (int c = 0; c < 4; c++) begin
      set_data(400 + c);
      if (c == 2) req = '0;
      step("hold");
      chk("hold.sel", (DW+4)'(out_sel), (DW+4)'(7));
    end
    req = '1; out_ready = 1'b1; set_data(500);
    step("reload");
    chk("reload.sel", (DW+4)'(out_sel), (DW+4)'(8));

    // drain to idle; out_ready while idle is ignored
    req = '0; step("drain");
    step("idle_rdy");
    out_ready = 1'b0; step("idle_nrdy");
    out_ready = 1'b1;

    // reset while holding a word
    req = 16'h0200; set_data(600); step("load9");
    chk("load9.sel", (DW+4)'(out_sel), (DW+4)'(9));
    rst_n = 1'b0; step("midrst");
    rst_n = 1'b1; req = '1; set_data(700); step("post_rst");
    chk("post_rst.sel", (DW+4)'(out_sel), (DW+4)'(0));

`ifdef ARB_LOCK_EN
    req = 16'h0011; lock = 16'h0010;
    for (int c = 0; c < 3; c++) begin
      set_data(800 + c);
      step("lock");
      chk("lock.seq", (DW+4)'(out_sel), (DW+4)'(4));
    end
    lock = '0;
    step("unlock0"); chk("unlock0.seq", (DW+4)'(out_sel), (DW+4)'(4));
    step("unlock1"); chk("unlock1.seq", (DW+4)'(out_sel), (DW+4)'(0));
`endif

    req = '0; step("end");
    chk("sb.empty", (DW+4)'(sb.size()), (DW+4)'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
